alu_seq: RTL and testbench

//  Parametrised, handshaked successor to the core ALU. Adds XOR and shifts, and

---
 rtl/alu_seq_if.sv | 29 ++
 rtl/alu_seq.sv | 227 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Handshake bundle for alu_seq: request side (in_*, operands, opcode) and
// response side (out_*, result, flags, op_err, busy).
interface alu_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [3:0]       alu_control;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_result;
    logic [3:0]       flags;
    logic             op_err;
    logic             busy;

    // Issue/writeback side driving requests and consuming results.
    modport master (
        output in_valid, src_a, src_b, alu_control, out_ready,
        input  in_ready, out_valid, alu_result, flags, op_err, busy
    );

    // The ALU itself.
    modport slave (
        input  in_valid, src_a, src_b, alu_control, out_ready,
        output in_ready, out_valid, alu_result, flags, op_err, busy
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked sequential ALU. One operation in flight at a time: accepted in
// IDLE, result registered and held in DONE until the consumer takes it.
// Flags are {N,Z,C,V}; C and V only come from ADD/SUB.
// Optional feature macro MULDIV_EN: when defined, opcodes 9-11 (MUL low,
// DIVU, REMU) run iteratively one bit per cycle in BUSY. When undefined they
// are reported as undefined opcodes and no mul/div datapath exists.
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);
    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpSub  = 4'd1;
    localparam logic [3:0] OpAnd  = 4'd2;
    localparam logic [3:0] OpOr   = 4'd3;
    localparam logic [3:0] OpSlt  = 4'd4;
    localparam logic [3:0] OpXor  = 4'd5;
    localparam logic [3:0] OpSll  = 4'd6;
    localparam logic [3:0] OpSrl  = 4'd7;
    localparam logic [3:0] OpSra  = 4'd8;
`ifdef MULDIV_EN
    localparam logic [3:0] OpMul  = 4'd9;
    localparam logic [3:0] OpDivu = 4'd10;
    localparam logic [3:0] OpRemu = 4'd11;
`endif

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;
    logic             op_err_q;

    // Single-cycle datapath, evaluated on the live request so the result can be
    // registered at the accept edge.
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [3:0]         op;
    logic               is_add;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     sum;
    logic               ovf;
    logic [SHAMT_W-1:0] shamt;

    assign a      = bus.src_a;
    assign b      = bus.src_b;
    assign op     = bus.alu_control;
    // Everything but ADD uses a + ~b + 1 (SUB and SLT).
    assign is_add = (op == OpAdd);
    assign b_eff  = is_add ? b : ~b;
    assign sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, ~is_add};
    // Overflow: both addends share a sign that the sum does not.
    assign ovf    = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign shamt  = b[SHAMT_W-1:0];

    logic [WIDTH-1:0] sc_result;
    logic [3:0]       sc_flags;
    logic             sc_c;
    logic             sc_v;
    logic             sc_err;
`ifdef MULDIV_EN
    logic             sc_iter;
`endif

    // Decode opcode into a single-cycle result, or flag it as iterative/undefined.
    always_comb begin
        sc_result = '0;
        sc_c      = 1'b0;
        sc_v      = 1'b0;
        sc_err    = 1'b0;
`ifdef MULDIV_EN
        sc_iter   = 1'b0;
`endif
        case (op)
            OpAdd, OpSub: begin
                sc_result = sum[WIDTH-1:0];
                sc_c      = sum[WIDTH];
                sc_v      = ovf;
            end
            OpAnd: sc_result = a & b;
            OpOr:  sc_result = a | b;
            OpXor: sc_result = a ^ b;
            OpSlt: sc_result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
            OpSll: sc_result = a << shamt;
            OpSrl: sc_result = a >> shamt;
            OpSra: sc_result = $unsigned($signed(a) >>> shamt);
`ifdef MULDIV_EN
            OpMul, OpDivu, OpRemu: sc_iter = 1'b1;
`endif
            default: sc_err = 1'b1;
        endcase
        sc_flags = sc_err ? 4'b0000 : {sc_result[WIDTH-1], ~|sc_result, sc_c, sc_v};
    end

`ifdef MULDIV_EN
    // Iterative state: acc = product / partial remainder, opa = multiplicand /
    // dividend-then-quotient, opb = multiplier / divisor.
    logic               busy_q;
    logic               is_mul_q;
    logic               is_rem_q;
    logic [SHAMT_W-1:0] count_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   opa_q;
    logic [WIDTH-1:0]   opb_q;

    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   diff;
    logic               ge;
    logic [WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]   opa_nxt;
    logic [WIDTH-1:0]   opb_nxt;
    logic [WIDTH-1:0]   it_result;

    // One shift-add multiply step or one restoring-division step per cycle.
    always_comb begin
        trial = {acc_q, opa_q[WIDTH-1]};
        ge    = (trial >= {1'b0, opb_q});
        // When ge holds the difference is below the divisor, so low bits suffice.
        diff  = trial[WIDTH-1:0] - opb_q;
        if (is_mul_q) begin
            acc_nxt   = acc_q + (opb_q[0] ? opa_q : '0);
            opa_nxt   = opa_q << 1;
            opb_nxt   = opb_q >> 1;
            it_result = acc_nxt;
        end else begin
            // Divide by zero falls out naturally: every step subtracts, giving an
            // all-ones quotient and the dividend shifted fully into the remainder.
            acc_nxt   = ge ? diff : trial[WIDTH-1:0];
            opa_nxt   = {opa_q[WIDTH-2:0], ge};
            opb_nxt   = opb_q;
            it_result = is_rem_q ? acc_nxt : opa_nxt;
        end
    end

    assign bus.busy = busy_q;
`else
    assign bus.busy = 1'b0;
`endif

    // Control FSM; all handshake and result outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            op_err_q    <= 1'b0;
`ifdef MULDIV_EN
            busy_q      <= 1'b0;
            is_mul_q    <= 1'b0;
            is_rem_q    <= 1'b0;
            count_q     <= '0;
            acc_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        in_ready_q <= 1'b0;
`ifdef MULDIV_EN
                        if (sc_iter) begin
                            state_q  <= StBusy;
                            busy_q   <= 1'b1;
                            count_q  <= '0;
                            acc_q    <= '0;
                            opa_q    <= bus.src_a;
                            opb_q    <= bus.src_b;
                            is_mul_q <= (op == OpMul);
                            is_rem_q <= (op == OpRemu);
                        end else
`endif
                        begin
                            state_q     <= StDone;
                            out_valid_q <= 1'b1;
                            result_q    <= sc_result;
                            flags_q     <= sc_flags;
                            op_err_q    <= sc_err;
                        end
                    end
                end
`ifdef MULDIV_EN
                StBusy: begin
                    acc_q   <= acc_nxt;
                    opa_q   <= opa_nxt;
                    opb_q   <= opb_nxt;
                    count_q <= count_q + SHAMT_W'(1);
                    if (count_q == SHAMT_W'(WIDTH - 1)) begin
                        state_q     <= StDone;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        result_q    <= it_result;
                        flags_q     <= {it_result[WIDTH-1], ~|it_result, 2'b00};
                        op_err_q    <= 1'b0;
                    end
                end
`endif
                StDone: begin
                    if (bus.out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.alu_result = result_q;
    assign bus.flags      = flags_q;
    assign bus.op_err     = op_err_q;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32). A cycle-level reference model
// tracks the outstanding operation and its expected result; directed cases pin
// known values and random operations exercise the rest. Honours MULDIV_EN.
module tb_alu_seq;
    localparam int unsigned W = 32;

    logic clk;
    logic rst;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    // Reference: what an operation must return, from plain arithmetic.
    function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r,
                                  output logic [3:0] f, output logic e, output int lat);
        longint sa, sb, s, lim;
        logic [32:0] wide;
        logic c, v;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lim = 64'sh8000_0000;
        r = '0; c = 1'b0; v = 1'b0; e = 1'b0; lat = 1;
        case (op)
            4'd0: begin
                r = a + b; wide = {1'b0, a} + {1'b0, b}; c = wide[32];
                s = sa + sb; v = (s >= lim) || (s < -lim);
            end
            4'd1: begin
                r = a - b; c = (a >= b);
                s = sa - sb; v = (s >= lim) || (s < -lim);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd5: r = a ^ b;
            4'd6: r = a << b[4:0];
            4'd7: r = a >> b[4:0];
            4'd8: r = $unsigned($signed(a) >>> b[4:0]);
`ifdef MULDIV_EN
            4'd9:  begin r = a * b; lat = W + 1; end
            4'd10: begin r = (b == 0) ? 32'hFFFF_FFFF : a / b; lat = W + 1; end
            4'd11: begin r = (b == 0) ? a : a % b; lat = W + 1; end
`endif
            default: e = 1'b1;
        endcase
        f = e ? 4'b0000 : {r[31], r == 32'd0, c, v};
    endfunction

    // Per-cycle compare against the model's view of the outstanding operation.
    initial begin
        bit          out_st;
        int          left;
        int          mlat;
        logic [31:0] er;
        logic [3:0]  ef;
        logic        ee;
        out_st = 1'b0;
        left   = 0;
        er = '0; ef = '0; ee = 1'b0;
        forever begin
            @(posedge clk);
            if (rst) begin
                out_st = 1'b0;
            end else if (!out_st) begin
                if (bus.in_valid) begin
                    model(bus.alu_control, bus.src_a, bus.src_b, er, ef, ee, mlat);
                    out_st = 1'b1;
                    left   = mlat - 1;
                end
            end else if (left > 0) begin
                left--;
            end else if (bus.out_ready) begin
                out_st = 1'b0;
            end
            #1;
            check("cyc_in_ready", bus.in_ready, !out_st);
            check("cyc_out_valid", bus.out_valid, out_st && left == 0);
            check("cyc_busy", bus.busy, out_st && left > 0);
            if (out_st && left == 0) begin
                check("cyc_result", bus.alu_result, er);
                check("cyc_flags", bus.flags, ef);
                check("cyc_op_err", bus.op_err, ee);
            end
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, wait for the result, hold it for 'hold' cycles with junk
    // requests pending, then consume it. Called at a negedge, returns at one.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit junk, output logic [31:0] r,
                         output logic [3:0] f, output logic e, output int lat);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("idle_wait", bus.in_ready, 1'b1);
        bus.in_valid    = 1'b1;
        bus.alu_control = op;
        bus.src_a       = a;
        bus.src_b       = b;
        bus.out_ready   = 1'b0;
        @(posedge clk);
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) break;
            bus.out_ready = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.in_valid  = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.src_a     = $urandom;
            bus.src_b     = $urandom;
        end
        check("result_wait", bus.out_valid, 1'b1);
        r = bus.alu_result;
        f = bus.flags;
        e = bus.op_err;
        for (int i = 0; i < hold; i++) begin
            bus.out_ready   = 1'b0;
            bus.in_valid    = 1'b1;
            bus.alu_control = 4'($urandom_range(0, 15));
            bus.src_a       = $urandom;
            bus.src_b       = $urandom;
            @(negedge clk);
            check("hold_in_ready", bus.in_ready, 1'b0);
            check("hold_result", bus.alu_result, r);
            check("hold_flags", bus.flags, f);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("release_in_ready", bus.in_ready, 1'b1);
        check("release_out_valid", bus.out_valid, 1'b0);
    endtask

    task automatic dir(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] xr, input logic [3:0] xf,
                       input logic xe, input int xlat, input int hold);
        logic [31:0] r;
        logic [3:0]  f;
        logic        e;
        int          lat;
        do_op(op, a, b, hold, 1'b0, r, f, e, lat);
        check({name, "_result"}, r, xr);
        check({name, "_flags"}, f, xf);
        check({name, "_op_err"}, e, xe);
        check({name, "_latency"}, 64'(lat), 64'(xlat));
    endtask

    initial begin
        logic [31:0] r;
        logic [3:0]  f;
        logic        e;
        int          lat;

        // Pin the model itself with hand-computed values.
        model(4'd0, 32'h7FFF_FFFF, 32'd1, r, f, e, lat);
        check("model_add_ovf", {f, r}, {4'b1001, 32'h8000_0000});
        model(4'd1, 32'd0, 32'd1, r, f, e, lat);
        check("model_sub_borrow", {f, r}, {4'b1000, 32'hFFFF_FFFF});
        model(4'd8, 32'h8000_0000, 32'h24, r, f, e, lat);
        check("model_sra", r, 32'hF800_0000);

        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b0;
        bus.src_a       = '0;
        bus.src_b       = '0;
        bus.alu_control = '0;
        repeat (2) @(negedge clk);
        check("rst_result", bus.alu_result, 32'd0);
        check("rst_flags", bus.flags, 4'd0);
        check("rst_op_err", bus.op_err, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        dir("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b1001, 1'b0, 1, 0);
        dir("sub_zero", 4'd1, 32'd5, 32'd5, 32'd0, 4'b0110, 1'b0, 1, 0);
        dir("slt_neg", 4'd4, 32'hFFFF_FFFF, 32'd1, 32'd1, 4'b0000, 1'b0, 1, 0);
        dir("sra", 4'd8, 32'h8000_0000, 32'h24, 32'hF800_0000, 4'b1000, 1'b0, 1, 0);
        dir("xor", 4'd5, 32'hF0F0, 32'h0FF0, 32'hFF00, 4'b0000, 1'b0, 1, 0);
        dir("backpressure", 4'd0, 32'd10, 32'd20, 32'd30, 4'b0000, 1'b0, 1, 5);
        dir("undef_f", 4'hF, 32'd3, 32'd4, 32'd0, 4'b0000, 1'b1, 1, 0);
`ifdef MULDIV_EN
        dir("mul", 4'd9, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 4'b1000, 1'b0, 33, 0);
        dir("divu", 4'd10, 32'd100, 32'd7, 32'd14, 4'b0000, 1'b0, 33, 0);
        dir("remu", 4'd11, 32'd100, 32'd7, 32'd2, 4'b0000, 1'b0, 33, 2);
        dir("divu_zero", 4'd10, 32'd9, 32'd0, 32'hFFFF_FFFF, 4'b1000, 1'b0, 33, 0);
        dir("remu_zero", 4'd11, 32'd9, 32'd0, 32'd9, 4'b0000, 1'b0, 33, 0);
`else
        dir("undef_9", 4'd9, 32'd3, 32'd4, 32'd0, 4'b0000, 1'b1, 1, 0);
`endif

        // Reset in the middle of an operation aborts it.
        bus.in_valid = 1'b1;
`ifdef MULDIV_EN
        bus.alu_control = 4'd9;
`else
        bus.alu_control = 4'd0;
`endif
        bus.src_a = 32'h1234_5678;
        bus.src_b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
`ifdef MULDIV_EN
        check("mid_busy", bus.busy, 1'b1);
`endif
        rst = 1'b1;
        #1;
        check("abort_out_valid", bus.out_valid, 1'b0);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_result", bus.alu_result, 32'd0);
        check("abort_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        dir("add_after_rst", 4'd0, 32'd2, 32'd3, 32'd5, 4'b0000, 1'b0, 1, 0);

        for (int i = 0; i < 400; i++) begin
            do_op(4'($urandom_range(0, 15)), pick(), pick(), $urandom_range(0, 3), 1'b1,
                  r, f, e, lat);
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
